hazard_ctl: RTL



---
 rtl/hazard_ctl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: RAW interlock via a 3-stage destination scoreboard,
// branch-redirect flushes, and HALT drain sequencing with a saturating stall counter.
module hazard_ctl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [2:0]  id_src1_num,
    input  logic [2:0]  id_src2_num,
    input  logic        id_src1_used,
    input  logic        id_src2_used,
    input  logic [2:0]  id_dst_num,
    input  logic        id_RegWriteEN,
    input  logic        id_dump,
    input  logic        ex_redirect,
    output logic        stall,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    localparam int unsigned REG_W   = 3;
    localparam int unsigned SLOT_W  = REG_W + 1;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DRAIN_W = 2;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_n;

    // Slots are {valid, dst}; an invalid slot is held at all-zero.
    logic [SLOT_W-1:0]    ex_slot, mem_slot, wb_slot, ex_slot_n;
    logic                 raw, issue;

    function automatic logic slot_hit(input logic [SLOT_W-1:0] slot,
                                      input logic [REG_W-1:0]  num);
        return slot[SLOT_W-1] && (slot[REG_W-1:0] == num);
    endfunction

    // WB is deliberately excluded: the register file bypasses write-to-read.
    assign raw = id_valid &&
                 ((id_src1_used && (slot_hit(ex_slot, id_src1_num) || slot_hit(mem_slot, id_src1_num))) ||
                  (id_src2_used && (slot_hit(ex_slot, id_src2_num) || slot_hit(mem_slot, id_src2_num))));

    assign issue     = id_valid && !raw && !ex_redirect && (state == RUN);
    assign ex_slot_n = (issue && id_RegWriteEN) ? {1'b1, id_dst_num} : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_cnt_n;
        end
    end

    // Next state and control outputs
    always_comb begin
        state_n     = state;
        drain_cnt_n = drain_cnt;
        stall       = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        unique case (state)
            RUN: begin
                stall       = raw && !ex_redirect;
                idex_bubble = raw || ex_redirect;
                ifid_flush  = ex_redirect;
                if (issue && id_dump) begin
                    state_n     = DRAIN;
                    drain_cnt_n = '0;
                end
            end
            DRAIN: begin
                stall       = 1'b1;
                idex_bubble = 1'b1;
                drain_cnt_n = drain_cnt + DRAIN_W'(1);
                if (drain_cnt == DRAIN_LAST) begin
                    state_n = HALTED;
                end
            end
            HALTED: begin
                stall       = 1'b1;
                idex_bubble = 1'b1;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    // Scoreboard shift, halted flag and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_slot      <= '0;
            mem_slot     <= '0;
            wb_slot      <= '0;
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= ex_slot_n;
            halted   <= (state_n == HALTED);
            if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    // By the time the machine is halted the dump and everything ahead of it has retired.
    a_halted_empty: assert property (@(posedge clk) disable iff (rst)
        (state == HALTED) |-> (ex_slot == '0 && mem_slot == '0 && wb_slot == '0));

endmodule
